// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and defaults for the two-port SRAM arbiter:
//               FSM state encoding, SRAM bus width defaults, port index type.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int c_ADDR_W_DEF = 18;
    localparam int c_DATA_W_DEF = 16;

    // Explicit 2-bit encoding keeps the state register width fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Requester index: 0 = port 0, 1 = port 1.
    typedef logic port_idx_t;

    localparam port_idx_t c_PORT0 = 1'b0;
    localparam port_idx_t c_PORT1 = 1'b1;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational winner select between two requesters plus the
//               last-grant register used for round-robin tie breaking.
//               Macro SRAM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins
//               ties and no last-grant state is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_req0,
    input  logic      i_req1,
    input  logic      i_take,
    output port_idx_t o_winner
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Clock, reset and grant strobe have no role with static priority.
    logic w_unused_fixed;
    assign w_unused_fixed = &{1'b0, i_clk, i_reset_n, i_take};

    // Port 0 wins whenever it requests.
    always_comb begin
        o_winner = i_req0 ? c_PORT0 : c_PORT1;
    end
`else
    port_idx_t r_last_grant;

    // A lone requester wins; a tie goes to the port not granted last.
    always_comb begin
        if (i_req0 && i_req1) begin
            o_winner = (r_last_grant == c_PORT1) ? c_PORT0 : c_PORT1;
        end else if (i_req1) begin
            o_winner = c_PORT1;
        end else begin
            o_winner = c_PORT0;
        end
    end

    // Remember every grant; reset favours port 0 on the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_last_grant <= c_PORT1;
        end else if (i_take) begin
            r_last_grant <= o_winner;
        end
    end
`endif

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port arbiter for an asynchronous SRAM. Each access runs
//               IDLE -> SETUP -> ACCESS (READ_WAIT cycles for reads, 1 for
//               writes) -> HOLD, with every SRAM pin driven from a register.
//               Macro SRAM_ARB_FIXED_PRIO_EN (in sram_arb_pick) selects fixed
//               port-0 priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W_DEF,
    parameter int DATA_W    = c_DATA_W_DEF,
    parameter int READ_WAIT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              forward_enable,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    inout  wire  [DATA_W-1:0] sram_DQ_mem,
    output logic [ADDR_W-1:0] sram_ADDR_mem,
    output logic              sram_UB_N_mem,
    output logic              sram_LB_N_mem,
    output logic              sram_WE_N_mem,
    output logic              sram_CE_N_mem,
    output logic              sram_OE_N_mem
);

    localparam logic [1:0] c_LAST_WAIT = 2'(READ_WAIT - 1);

    state_t            r_state, w_next;
    logic [1:0]        r_wait;
    port_idx_t         r_port, w_winner, w_sel_port;
    logic              r_we, w_sel_we;
    logic [DATA_W-1:0] r_wdata, w_sel_wdata;
    logic [1:0]        r_be, w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_grant;

    // Registered pin images and their next values.
    logic              r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe, r_ack0, r_ack1;
    logic              w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_dq_oe, w_ack0, w_ack1;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_dq_out, w_dq_out, r_rdata;

    assign w_grant = (r_state == ST_IDLE) && forward_enable && (req0 || req1);

    sram_arb_pick u_pick (
        .i_clk     (CLOCK_50),
        .i_reset_n (reset),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_take    (w_grant),
        .o_winner  (w_winner)
    );

    // On a grant the winner's live inputs are used; afterwards the latched copy.
    assign w_sel_port  = w_grant ? w_winner : r_port;
    assign w_sel_we    = w_grant ? ((w_winner == c_PORT1) ? we1    : we0)    : r_we;
    assign w_sel_addr  = w_grant ? ((w_winner == c_PORT1) ? addr1  : addr0)  : r_addr;
    assign w_sel_wdata = w_grant ? ((w_winner == c_PORT1) ? wdata1 : wdata0) : r_wdata;
    assign w_sel_be    = w_grant ? ((w_winner == c_PORT1) ? be1    : be0)    : r_be;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: reads stay in ACCESS for READ_WAIT cycles, writes for one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (r_we || (r_wait == c_LAST_WAIT)) w_next = ST_HOLD;
            ST_HOLD:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output logic: pin values for the state being entered, registered below.
    always_comb begin
        w_ce_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_we_n   = 1'b1;
        w_ub_n   = 1'b1;
        w_lb_n   = 1'b1;
        w_dq_oe  = 1'b0;
        w_dq_out = r_dq_out;
        w_addr   = r_addr;
        w_ack0   = 1'b0;
        w_ack1   = 1'b0;
        if (w_next != ST_IDLE) begin
            w_ce_n   = 1'b0;
            w_addr   = w_sel_addr;
            w_ub_n   = ~w_sel_be[1];
            w_lb_n   = ~w_sel_be[0];
            w_dq_oe  = w_sel_we;
            w_dq_out = w_sel_wdata;
        end
        case (w_next)
            ST_SETUP:  w_oe_n = w_sel_we;
            ST_ACCESS: begin
                w_oe_n = w_sel_we;
                w_we_n = ~w_sel_we;
            end
            ST_HOLD: begin
                w_ack0 = (w_sel_port == c_PORT0);
                w_ack1 = (w_sel_port == c_PORT1);
            end
            default: ;
        endcase
    end

    // SRAM pin and ack registers; reset parks the bus idle with nothing acked.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_ub_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_dq_out <= '0;
            r_addr   <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
        end else begin
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_ub_n   <= w_ub_n;
            r_lb_n   <= w_lb_n;
            r_dq_oe  <= w_dq_oe;
            r_dq_out <= w_dq_out;
            r_addr   <= w_addr;
            r_ack0   <= w_ack0;
            r_ack1   <= w_ack1;
        end
    end

    // Latch the granted request so later input changes are ignored.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_port  <= c_PORT0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_grant) begin
            r_port  <= w_winner;
            r_we    <= w_sel_we;
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
        end
    end

    // Count read wait cycles spent in ACCESS.
    always_ff @(posedge CLOCK_50) begin
        if (!reset || (r_state == ST_SETUP)) begin
            r_wait <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_wait <= r_wait + 2'd1;
        end
    end

    // Capture read data on the last ACCESS edge; held otherwise.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if ((r_state == ST_ACCESS) && (w_next == ST_HOLD) && !r_we) begin
            r_rdata <= sram_DQ_mem;
        end
    end

    assign sram_DQ_mem   = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
    assign sram_ADDR_mem = r_addr;
    assign sram_CE_N_mem = r_ce_n;
    assign sram_OE_N_mem = r_oe_n;
    assign sram_WE_N_mem = r_we_n;
    assign sram_UB_N_mem = r_ub_n;
    assign sram_LB_N_mem = r_lb_n;
    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign rdata         = r_rdata;
    assign busy          = (r_state != ST_IDLE);

endmodule : sram_arbiter
`default_nettype wire
